// File: rtl/sevseg_pkg.sv
// Shared constants and helpers for the seven-segment scanner:
// hex glyph table and output polarity mapping.
package sevseg_pkg;

  // Active-high {g,f,e,d,c,b,a} patterns for hex digits 0..F.
  localparam logic [6:0] GLYPH [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Map an active-high "on" request to the physical pin level.
  function automatic logic to_pin(input logic on, input bit active_low);
    return on ^ active_low;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sevseg_hex_decoder.sv
// Combinational hex nibble to active-high seven-segment glyph.
module sevseg_hex_decoder
  import sevseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb o_seg = GLYPH[i_nibble];

endmodule

// File: rtl/sevseg_scan_n.sv
// N-digit multiplexed seven-segment scanner with shadow registers, blink,
// leading-zero suppression, PWM brightness and inter-slot dead time.
module sevseg_scan_n
  import sevseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV_W = 16,
  parameter int unsigned BLINK_W    = 25,
  parameter int unsigned BRIGHT_W   = 3,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [4*NUM_DIGITS-1:0]           digits_in,
  input  logic [NUM_DIGITS-1:0]             dp_in,
  input  logic [NUM_DIGITS-1:0]             digit_en_in,
  input  logic [NUM_DIGITS-1:0]             blink_in,
  input  logic                              lz_blank,
  input  logic [BRIGHT_W-1:0]               brightness,
  input  logic                              load,
  output logic [6:0]                        seg,
  output logic                              dp,
  output logic [NUM_DIGITS-1:0]             an,
  output logic [idx_width(NUM_DIGITS)-1:0]  scan_idx
);

  localparam int unsigned      IDX_W    = idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_DIV_W-1:0]   r_presc;
  logic [IDX_W-1:0]        r_idx;
  logic [BLINK_W-1:0]      r_blink;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dp_sh;
  logic [NUM_DIGITS-1:0]   r_en_sh;
  logic [NUM_DIGITS-1:0]   r_blink_sh;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic [3:0]              w_nibble;
  logic [6:0]              w_glyph;
  logic [NUM_DIGITS-1:0]   w_lz;
  logic                    w_run;
  logic [BRIGHT_W-1:0]     w_slice;
  logic                    w_blank;
  logic                    w_lit;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [6:0]              w_seg_nxt;
  logic                    w_dp_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic [6:0]              w_seg_pin;
  logic                    w_dp_pin;
  logic [NUM_DIGITS-1:0]   w_an_pin;

  assign seg      = r_seg;
  assign dp       = r_dp;
  assign an       = r_an;
  assign scan_idx = r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_blink <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
      r_blink <= r_blink + 1'b1;
      if (&r_presc)
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits   <= '0;
      r_dp_sh    <= '0;
      r_en_sh    <= '0;
      r_blink_sh <= '0;
    end else if (load) begin
      r_digits   <= digits_in;
      r_dp_sh    <= dp_in;
      r_en_sh    <= digit_en_in;
      r_blink_sh <= blink_in;
    end
  end

  assign w_nibble = r_digits[{r_idx, 2'b00} +: 4];

  sevseg_hex_decoder u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_glyph)
  );

  // Suppression runs from the most significant digit down; it stops at the
  // first digit that is non-zero or carries a decimal point.
  always_comb begin
    w_lz  = '0;
    w_run = 1'b1;
    for (int unsigned i = NUM_DIGITS; i > 1; i--) begin
      w_run     = w_run & (r_digits[4*(i-1) +: 4] == 4'h0) & ~r_dp_sh[i-1];
      w_lz[i-1] = w_run;
    end
  end

  always_comb begin
    w_onehot        = '0;
    w_onehot[r_idx] = 1'b1;
  end

  assign w_slice = r_presc[SCAN_DIV_W-1 -: BRIGHT_W];
  assign w_blank = ~r_en_sh[r_idx]
                 | (r_blink[BLINK_W-1] & r_blink_sh[r_idx])
                 | (lz_blank & w_lz[r_idx]);
  // Prescaler value 0 is the dead-time cycle separating adjacent slots.
  assign w_lit   = ~w_blank & (r_presc != '0)
                 & ((&brightness) | (w_slice < brightness));

  always_comb begin
    w_seg_nxt = w_blank ? 7'b0000000 : w_glyph;
    w_dp_nxt  = ~w_blank & r_dp_sh[r_idx];
    w_an_nxt  = w_lit ? w_onehot : '0;
  end

  always_comb begin
    w_seg_pin = '0;
    w_an_pin  = '0;
    for (int unsigned b = 0; b < 7; b++)
      w_seg_pin[b] = to_pin(w_seg_nxt[b], ACTIVE_LOW);
    for (int unsigned d = 0; d < NUM_DIGITS; d++)
      w_an_pin[d] = to_pin(w_an_nxt[d], ACTIVE_LOW);
    w_dp_pin = to_pin(w_dp_nxt, ACTIVE_LOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= {7{ACTIVE_LOW}};
      r_dp  <= ACTIVE_LOW;
      r_an  <= {NUM_DIGITS{ACTIVE_LOW}};
    end else begin
      r_seg <= w_seg_pin;
      r_dp  <= w_dp_pin;
      r_an  <= w_an_pin;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_n.sv
// Directed bench for sevseg_scan_n: a 4-digit and a 3-digit instance with a
// 16-cycle slot; expectations are queued with their target cycle and checked there.
module tb_sevseg_scan_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp_in, en_in, bl_in;
  logic        lz;
  logic [2:0]  br;
  logic        load;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [3:0]  an_a;
  logic [2:0]  an_b;
  logic [1:0]  idx_a, idx_b;

  int unsigned cyc;
  int          total = 0;
  int          bad   = 0;

  typedef struct {
    string       tag;
    bit          sel;
    int unsigned at;
    bit          chk_seg;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic [1:0]  idx;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  sevseg_scan_n #(
    .NUM_DIGITS (4), .SCAN_DIV_W (4), .BLINK_W (6), .BRIGHT_W (3), .ACTIVE_LOW (1'b1)
  ) u_dut_a (
    .clk (clk), .rst_n (rst_n),
    .digits_in (digits), .dp_in (dp_in), .digit_en_in (en_in), .blink_in (bl_in),
    .lz_blank (lz), .brightness (br), .load (load),
    .seg (seg_a), .dp (dp_a), .an (an_a), .scan_idx (idx_a)
  );

  sevseg_scan_n #(
    .NUM_DIGITS (3), .SCAN_DIV_W (4), .BLINK_W (6), .BRIGHT_W (3), .ACTIVE_LOW (1'b1)
  ) u_dut_b (
    .clk (clk), .rst_n (rst_n),
    .digits_in (digits[11:0]), .dp_in (dp_in[2:0]), .digit_en_in (en_in[2:0]),
    .blink_in (bl_in[2:0]), .lz_blank (lz), .brightness (br), .load (load),
    .seg (seg_b), .dp (dp_b), .an (an_b), .scan_idx (idx_b)
  );

  task automatic cmp(input string tag, input bit sel, input bit chk_seg,
                     input logic [6:0] s, input logic d, input logic [3:0] a,
                     input logic [1:0] ix);
    logic [6:0] os;
    logic       od;
    logic [3:0] oa;
    logic [1:0] oi;
    os = sel ? seg_b : seg_a;
    od = sel ? dp_b : dp_a;
    oa = sel ? {1'b0, an_b} : an_a;
    oi = sel ? idx_b : idx_a;
    total++;
    if (chk_seg) begin
      assert ({os, od, oa, oi} === {s, d, a, ix}) else begin
        bad++;
        $error("FAIL %s: seg/dp/an/idx observed %b/%b/%b/%0d expected %b/%b/%b/%0d",
               tag, os, od, oa, oi, s, d, a, ix);
      end
    end else begin
      assert ({od, oa, oi} === {d, a, ix}) else begin
        bad++;
        $error("FAIL %s: dp/an/idx observed %b/%b/%0d expected %b/%b/%0d",
               tag, od, oa, oi, d, a, ix);
      end
    end
  endtask

  // Output after edge c reflects the state before that edge; scan_idx is the
  // live register, i.e. the slot count after edge c.
  task automatic push(input bit sel, input int unsigned at, input string tag,
                      input bit chk_seg, input logic [6:0] s, input logic d,
                      input logic [3:0] a);
    exp_t e;
    int unsigned n;
    n         = sel ? 3 : 4;
    e.tag     = tag;
    e.sel     = sel;
    e.at      = at;
    e.chk_seg = chk_seg;
    e.seg     = s;
    e.dp      = d;
    e.an      = a;
    e.idx     = 2'((at / 16) % n);
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    int   guard;
    while (q.size() > 0) begin
      e     = q.pop_front();
      guard = 0;
      while (cyc < e.at && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (cyc != e.at) begin
        total++;
        assert (cyc == e.at) else begin
          bad++;
          $error("FAIL %s: timing observed cycle %0d expected cycle %0d", e.tag, cyc, e.at);
        end
      end else begin
        cmp(e.tag, e.sel, e.chk_seg, e.seg, e.dp, e.an, e.idx);
      end
    end
  endtask

  task automatic do_reset(input logic [15:0] dg, input logic [3:0] dpv,
                          input logic [3:0] en, input logic [3:0] bl,
                          input logic lzv, input logic [2:0] brv);
    @(negedge clk);
    rst_n  = 1'b0;
    digits = dg;
    dp_in  = dpv;
    en_in  = en;
    bl_in  = bl;
    lz     = lzv;
    br     = brv;
    load   = 1'b1;
    #1;
    cmp("rst_a", 1'b0, 1'b1, 7'h7F, 1'b1, 4'b1111, 2'd0);
    cmp("rst_b", 1'b1, 1'b1, 7'h7F, 1'b1, 4'b0111, 2'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    digits = '0;
    dp_in  = '0;
    en_in  = '0;
    bl_in  = '0;
    lz     = 1'b0;
    br     = '0;

    // Basic scan of 3,2,1,0 at full brightness
    do_reset(16'h3210, 4'b0000, 4'b1111, 4'b0000, 1'b0, 3'd7);
    push(0, 2,  "d0_lit",  1, 7'b1000000, 1, 4'b1110);
    push(0, 16, "d0_end",  1, 7'b1000000, 1, 4'b1110);
    push(0, 17, "dead1",   1, 7'b1111001, 1, 4'b1111);
    push(0, 18, "d1_lit",  1, 7'b1111001, 1, 4'b1101);
    push(0, 40, "d2_lit",  1, 7'b0100100, 1, 4'b1011);
    push(0, 60, "d3_lit",  1, 7'b0110000, 1, 4'b0111);
    push(0, 64, "d3_end",  1, 7'b0110000, 1, 4'b0111);
    push(0, 65, "dead0",   1, 7'b1000000, 1, 4'b1111);
    drain();

    // Asynchronous reset mid-slot, then shadows must read back as cleared
    #2 rst_n = 1'b0;
    #1 cmp("async_rst", 1'b0, 1'b1, 7'h7F, 1'b1, 4'b1111, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 1, "rel_idx0", 1, 7'h7F, 1, 4'b1111);
    push(0, 2, "rst_clr",  1, 7'h7F, 1, 4'b1111);
    drain();

    // Leading-zero suppression
    do_reset(16'h0040, 4'b0000, 4'b1111, 4'b0000, 1'b1, 3'd7);
    push(0, 2,  "lz_d0", 1, 7'b1000000, 1, 4'b1110);
    push(0, 18, "lz_d1", 1, 7'b0011001, 1, 4'b1101);
    push(0, 34, "lz_d2", 1, 7'h7F,      1, 4'b1111);
    push(0, 50, "lz_d3", 1, 7'h7F,      1, 4'b1111);
    drain();

    do_reset(16'h0040, 4'b0100, 4'b1111, 4'b0000, 1'b1, 3'd7);
    push(0, 18, "lzdp_d1", 1, 7'b0011001, 1, 4'b1101);
    push(0, 34, "lzdp_d2", 1, 7'b1000000, 0, 4'b1011);
    push(0, 50, "lzdp_d3", 1, 7'h7F,      1, 4'b1111);
    drain();

    // Brightness 0 and 2
    do_reset(16'h3210, 4'b0000, 4'b1111, 4'b0000, 1'b0, 3'd0);
    push(0, 5,  "br0_a", 0, 7'h00, 1, 4'b1111);
    push(0, 25, "br0_b", 0, 7'h00, 1, 4'b1111);
    drain();

    do_reset(16'h3210, 4'b0000, 4'b1111, 4'b0000, 1'b0, 3'd2);
    push(0, 1,  "br2_dead",  0, 7'h00,      1, 4'b1111);
    push(0, 2,  "br2_on1",   1, 7'b1000000, 1, 4'b1110);
    push(0, 4,  "br2_on3",   1, 7'b1000000, 1, 4'b1110);
    push(0, 5,  "br2_off4",  0, 7'h00,      1, 4'b1111);
    push(0, 16, "br2_off15", 0, 7'h00,      1, 4'b1111);
    push(0, 18, "br2_d1",    1, 7'b1111001, 1, 4'b1101);
    drain();

    // 3-digit instance: blink on digit 1, mid-slot load, index wrap
    do_reset(16'h3210, 4'b0000, 4'b1111, 4'b0010, 1'b0, 3'd7);
    push(1, 18, "bl_d1_on", 1, 7'b1111001, 1, 4'b0101);
    drain();
    @(negedge clk);
    digits = 16'h3290;
    load   = 1'b1;
    push(1, 20, "ld_old", 1, 7'b1111001, 1, 4'b0101);
    push(1, 21, "ld_new", 1, 7'b0010000, 1, 4'b0101);
    drain();
    load = 1'b0;
    push(1, 47,  "n3_last",    1, 7'b0100100, 1, 4'b0011);
    push(1, 48,  "n3_wrap",    1, 7'b0100100, 1, 4'b0011);
    push(1, 50,  "bl_d0",      1, 7'b1000000, 1, 4'b0110);
    push(1, 66,  "bl_d1_on2",  1, 7'b0010000, 1, 4'b0101);
    push(1, 82,  "bl_d2",      1, 7'b0100100, 1, 4'b0011);
    push(1, 114, "bl_d1_off",  1, 7'h7F,      1, 4'b0111);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
